// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, 2-flop input synchronizer and registered pulse outputs.
// Optional even parity bit after bit 7 when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] byte_out,
    output logic       valid_out,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;
    logic             bit_done;

    assign rx_s     = sync2_q;
    assign bit_done = (cnt_q == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    logic pbad_q, pbad_d;
    logic perr_q, perr_d;
`endif

    // Input synchronizer; idles high so reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state and pulse generation; every sample point clears the baud counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d  = pbad_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // A high mid-start sample means the low was only a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    pbad_d  = rx_s ^ (^shift_q);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (pbad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            byte_d  = shift_q;
                        end
`else
                        valid_d = 1'b1;
                        byte_d  = shift_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign byte_out  = byte_q;
    assign valid_out = valid_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: frame table plus glitch, back-to-back,
// latency and mid-frame reset sequences. Build with UART_RX_PARITY_EN to add parity vectors.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS_PRE_STOP = 10;
`else
    localparam int NBITS_PRE_STOP = 9;
`endif
    localparam int LATENCY = NBITS_PRE_STOP * CPB + CPB / 2 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] byte_out;
    logic       valid_out, frame_err, parity_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .byte_out  (byte_out),
        .valid_out (valid_out),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         nvalid = 0, nferr = 0, nperr = 0, noverlap = 0;
    int         last_valid_cyc = 0;
    logic [7:0] rx_bytes[$];
    int         checks = 0, failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_out) begin
            nvalid++;
            last_valid_cyc = cyc;
            rx_bytes.push_back(byte_out);
        end
        if (frame_err)  nferr++;
        if (parity_err) nperr++;
        if (int'(valid_out) + int'(frame_err) + int'(parity_err) > 1) noverlap++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold_low;
        logic       par_flip;
        int         exp_valid;
        logic [7:0] exp_byte;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input logic s, input int h, input logic f,
                                input int ev, input logic [7:0] eb, input int ef, input int ep);
        vec_t v;
        v.data = d; v.stop = s; v.hold_low = h; v.par_flip = f;
        v.exp_valid = ev; v.exp_byte = eb; v.exp_ferr = ef; v.exp_perr = ep;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ flip);
`endif
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0, f0, p0, t0;
        logic [7:0] d55;

        vecs.push_back(mk(8'hE5, 1'b1, 0,   1'b0, 1, 8'hE5, 0, 0));
        vecs.push_back(mk(8'h3C, 1'b0, 100, 1'b0, 0, 8'hE5, 1, 0));
        vecs.push_back(mk(8'h81, 1'b1, 0,   1'b0, 1, 8'h81, 0, 0));
`ifdef UART_RX_PARITY_EN
        vecs.push_back(mk(8'h07, 1'b1, 0,   1'b1, 0, 8'h81, 0, 1));
        vecs.push_back(mk(8'h07, 1'b1, 0,   1'b0, 1, 8'h07, 0, 0));
        vecs.push_back(mk(8'hC3, 1'b0, 20,  1'b1, 0, 8'h07, 1, 0));
`endif
        vecs.push_back(mk(8'h5A, 1'b1, 0,   1'b0, 1, 8'h5A, 0, 0));

        repeat (5) @(negedge clk);
        chk("reset_byte_out", int'(byte_out), 0);
        chk("reset_valid", int'(valid_out), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        idle(2 * CPB);

        for (int i = 0; i < vecs.size(); i++) begin
            v0 = nvalid; f0 = nferr; p0 = nperr; t0 = cyc;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
            if (vecs[i].hold_low > 0) repeat (vecs[i].hold_low) @(negedge clk);
            idle(2 * CPB);
            chk($sformatf("vec%0d_valid_cnt", i), nvalid - v0, vecs[i].exp_valid);
            chk($sformatf("vec%0d_ferr_cnt", i), nferr - f0, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_perr_cnt", i), nperr - p0, vecs[i].exp_perr);
            chk($sformatf("vec%0d_byte_out", i), int'(byte_out), int'(vecs[i].exp_byte));
            if (i == 0) chk("latency_start_to_valid", last_valid_cyc - t0, LATENCY);
        end

        // Short low glitch must be rejected and leave the receiver ready.
        v0 = nvalid; f0 = nferr;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        chk("glitch_valid_cnt", nvalid - v0, 0);
        chk("glitch_ferr_cnt", nferr - f0, 0);
        send_frame(8'h96, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("post_glitch_valid_cnt", nvalid - v0, 1);
        chk("post_glitch_byte", int'(byte_out), 8'h96);

        // Back-to-back frames with zero idle time.
        v0 = nvalid;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("b2b_valid_cnt", nvalid - v0, 3);
        if (rx_bytes.size() >= 3) begin
            chk("b2b_byte0", int'(rx_bytes[rx_bytes.size()-3]), 8'h00);
            chk("b2b_byte1", int'(rx_bytes[rx_bytes.size()-2]), 8'hFF);
            chk("b2b_byte2", int'(rx_bytes[rx_bytes.size()-1]), 8'hA5);
        end else begin
            chk("b2b_queue_depth", rx_bytes.size(), 3);
        end

        // Reset during bit 4 of 0x55 aborts the frame silently.
        d55 = 8'h55;
        v0 = nvalid; f0 = nferr; p0 = nperr;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d55[i]);
        rx_in = d55[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_byte_out", int'(byte_out), 0);
        chk("rst_mid_valid", int'(valid_out), 0);
        chk("rst_mid_frame_err", int'(frame_err), 0);
        rx_in = 1'b1;
        rst = 1'b0;
        idle(3 * CPB);
        chk("rst_after_valid_cnt", nvalid - v0, 0);
        chk("rst_after_ferr_cnt", nferr - f0, 0);
        chk("rst_after_perr_cnt", nperr - p0, 0);
        chk("rst_after_byte_out", int'(byte_out), 0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("rst_next_valid_cnt", nvalid - v0, 1);
        chk("rst_next_byte", int'(byte_out), 8'h55);

        chk("pulse_overlap_cnt", noverlap, 0);
`ifndef UART_RX_PARITY_EN
        chk("parity_err_total", nperr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
